// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: round-robin Wishbone arbiter in front of the SDRAM controller.
// A master owns the slave port for a whole CYC (bursts included). Ownership
// rotates only at CYC boundaries. A watchdog ends any transfer that the slave
// never terminates by returning ERR to the owning master.
module sdram_wb_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_cyc,
    input  logic [NM-1:0]    m_stb,
    input  logic [NM-1:0]    m_we,
    input  logic [NM*AW-1:0] m_adr,
    input  logic [NM*DW-1:0] m_dat_w,
    input  logic [NM*3-1:0]  m_cti,
    output logic [NM-1:0]    m_ack,
    output logic [NM-1:0]    m_err,
    output logic [NM-1:0]    m_rty,
    output logic [DW-1:0]    m_dat_r,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [AW-1:0]    s_adr,
    output logic [DW-1:0]    s_dat_w,
    output logic [2:0]       s_cti,
    input  logic             s_ack,
    input  logic             s_err,
    input  logic             s_rty,
    input  logic [DW-1:0]    s_dat_r,
    output logic [NM-1:0]    gnt,
    output logic             timeout
);

    // Owner index width; a single-bit index is kept even for tiny NM.
    localparam int OW  = (NM > 1) ? $clog2(NM) : 1;
    // Watchdog counter must be able to hold TIMEOUT.
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS      = 2'd1,
        ERR_TERM = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  own_q, own_d;
    logic [OW-1:0]  last_q, last_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic [OW-1:0]  win;
    logic           term;

    // Signals of the current owner, selected by own_q.
    logic           sel_cyc;
    logic           sel_stb;
    logic           sel_we;
    logic [AW-1:0]  sel_adr;
    logic [DW-1:0]  sel_dat_w;
    logic [2:0]     sel_cti;

    assign sel_cyc   = m_cyc[own_q];
    assign sel_stb   = m_stb[own_q];
    assign sel_we    = m_we[own_q];
    assign sel_adr   = m_adr[own_q*AW +: AW];
    assign sel_dat_w = m_dat_w[own_q*DW +: DW];
    assign sel_cti   = m_cti[own_q*3 +: 3];

    assign term      = s_ack | s_err | s_rty;

    // Read data is broadcast; only the owner's ACK qualifies it.
    assign m_dat_r   = s_dat_r;

    // Round-robin pick: first requester searching upward from last+1, wrapping.
    always_comb begin
        int  idx;
        logic found;
        win   = own_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NM; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NM) begin
                idx = idx - NM;
            end
            if (!found && m_cyc[OW'(idx)]) begin
                win   = OW'(idx);
                found = 1'b1;
            end
        end
    end

    // Next-state logic: arbitration, ownership hold, watchdog and release.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        wd_d    = '0;
        case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    own_d   = win;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (!sel_cyc) begin
                    // Owner ended its cycle; any termination this cycle
                    // has already been passed through combinationally.
                    state_d = RELEASE;
                end else if (sel_stb && !term) begin
                    // A termination in the last allowed cycle beats the watchdog.
                    if (wd_q == WDW'(TIMEOUT - 1)) begin
                        state_d = ERR_TERM;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            ERR_TERM: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                last_d  = own_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: slave port and terminations routed only to/from the owner.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_cti   = 3'b000;
        m_ack   = '0;
        m_err   = '0;
        m_rty   = '0;
        gnt     = '0;
        timeout = 1'b0;
        case (state_q)
            BUS: begin
                s_cyc        = sel_cyc;
                s_stb        = sel_stb;
                s_we         = sel_we;
                s_adr        = sel_adr;
                s_dat_w      = sel_dat_w;
                s_cti        = sel_cti;
                m_ack[own_q] = s_ack;
                m_err[own_q] = s_err;
                m_rty[own_q] = s_rty;
                gnt[own_q]   = 1'b1;
            end
            ERR_TERM: begin
                // Slave sees the cycle aborted; owner sees an error.
                m_err[own_q] = 1'b1;
                gnt[own_q]   = 1'b1;
                timeout      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State registers; last starts at NM-1 so master 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= '0;
            last_q  <= OW'(NM - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Testbench for sdram_wb_arbiter (NM=2, TIMEOUT=8): directed stimulus with a
// scoreboard of expected terminations checked by an independent monitor.
module tb_sdram_wb_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic             clk;
    logic             rst;
    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat_w;
    logic [NM*3-1:0]  m_cti;
    logic [NM-1:0]    m_ack, m_err, m_rty;
    logic [DW-1:0]    m_dat_r;
    logic             s_cyc, s_stb, s_we;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_dat_w;
    logic [2:0]       s_cti;
    logic             s_ack, s_err, s_rty;
    logic [DW-1:0]    s_dat_r;
    logic [NM-1:0]    gnt;
    logic             timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] dat;
        logic [1:0]  g;
        logic        to;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    sdram_wb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_cti(m_cti),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_r(m_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_cti(s_cti),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_r(s_dat_r),
        .gnt(gnt), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat,
                        input logic [1:0] g, input logic to);
        exp_t e;
        e.ack = ack; e.err = err; e.dat = dat; e.g = g; e.to = to;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[i]           = cyc;
        m_stb[i]           = stb;
        m_we[i]            = we;
        m_adr[i*AW +: AW]  = adr;
        m_dat_w[i*DW +: DW] = adr ^ 32'h5A5A_0000;
        m_cti[i*3 +: 3]    = cti;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_cti = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_r = '0;
        tick();
        #1;
        check("rst_s_cyc", s_cyc, 0);
        check("rst_gnt", gnt, 0);
        check("rst_timeout", timeout, 0);
        check("rst_m_err", m_err, 0);
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every termination seen by a master must match the next expectation.
    always @(negedge clk) begin
        if (!rst && ((m_ack | m_err | m_rty) != 2'b00)) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_term: ack=%b err=%b rty=%b with nothing queued (t=%0t)",
                         m_ack, m_err, m_rty, $time);
            end else begin
                mon_e = sbq.pop_front();
                check("sb_m_ack", m_ack, mon_e.ack);
                check("sb_m_err", m_err, mon_e.err);
                check("sb_m_rty", m_rty, 0);
                check("sb_m_dat_r", m_dat_r, mon_e.dat);
                check("sb_gnt", gnt, mon_e.g);
                check("sb_timeout", timeout, mon_e.to);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int g;
        logic [1:0] oh;

        do_reset();

        // Single read by m0; slave acks at t3.
        set_m(0, 1, 1, 0, 32'h100, 3'b000);
        #1;
        check("t1_idle_s_cyc", s_cyc, 0);
        check("t1_idle_gnt", gnt, 0);
        tick(); #1;
        check("t1_s_cyc", s_cyc, 1);
        check("t1_gnt", gnt, 2'b01);
        check("t1_s_adr", s_adr, 32'h100);
        check("t1_s_stb", s_stb, 1);
        tick();
        tick();
        push(2'b01, 2'b00, 32'hDEADBEEF, 2'b01, 1'b0);
        s_ack = 1'b1; s_dat_r = 32'hDEADBEEF;
        tick();
        s_ack = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 3'b000);
        #1;
        check("t1_drop_s_cyc", s_cyc, 0);
        check("t1_drop_gnt", gnt, 2'b01);
        tick(); #1;
        check("t1_release_gnt", gnt, 0);
        tick();

        // Simultaneous requests after reset, then m1 burst with m0 waiting.
        do_reset();
        set_m(0, 1, 1, 0, 32'h400, 3'b000);
        set_m(1, 1, 0, 1, 32'h800, 3'b000);
        tick(); #1;
        check("t2_gnt_t1", gnt, 2'b01);
        check("t2_s_adr_t1", s_adr, 32'h400);
        tick();
        push(2'b01, 2'b00, 32'h11111111, 2'b01, 1'b0);
        s_ack = 1'b1; s_dat_r = 32'h11111111;
        tick();
        s_ack = 1'b0; m_stb[0] = 1'b0;
        tick();
        tick();
        m_cyc[0] = 1'b0;
        #1;
        check("t2_gnt_t5", gnt, 2'b01);
        tick(); #1;
        check("t2_gnt_t6", gnt, 0);
        check("t2_s_cyc_t6", s_cyc, 0);
        tick(); #1;
        check("t2_gnt_t7", gnt, 0);
        check("t2_s_cyc_t7", s_cyc, 0);
        tick(); #1;
        check("t2_gnt_t8", gnt, 2'b10);
        check("t2_s_cyc_t8", s_cyc, 1);
        check("t2_s_adr_t8", s_adr, 32'h800);
        check("t2_s_we_t8", s_we, 1);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) tick();
            if (b == 1) set_m(0, 1, 1, 0, 32'h300, 3'b000);
            set_m(1, 1, 1, 0, 32'h200 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
            push(2'b10, 2'b00, 32'hB0 + 32'(b), 2'b10, 1'b0);
            s_ack = 1'b1; s_dat_r = 32'hB0 + 32'(b);
            #1;
            check("t3_s_cti", s_cti, (b == 3) ? 3'b111 : 3'b010);
            check("t3_s_adr", s_adr, 32'h200 + 32'(4 * b));
        end
        tick();
        s_ack = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 3'b000);
        #1;
        check("t3_gnt_drop", gnt, 2'b10);
        tick(); #1;
        check("t3_gnt_release", gnt, 0);
        tick(); #1;
        check("t3_gnt_idle", gnt, 0);
        tick(); #1;
        check("t3_gnt_m0", gnt, 2'b01);
        check("t3_s_adr_m0", s_adr, 32'h300);
        set_m(0, 0, 0, 0, 32'h0, 3'b000);
        tick();
        tick();

        // Watchdog: slave never responds, STB high from t1.
        do_reset();
        s_dat_r = 32'h0;
        set_m(0, 1, 1, 0, 32'h500, 3'b000);
        push(2'b00, 2'b01, 32'h0, 2'b01, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            tick(); #1;
            check("t4_wait_timeout", timeout, 0);
            check("t4_wait_s_cyc", s_cyc, 1);
        end
        tick(); #1;
        check("t4_timeout_t9", timeout, 1);
        check("t4_s_cyc_t9", s_cyc, 0);
        check("t4_s_stb_t9", s_stb, 0);
        check("t4_m_err_t9", m_err, 2'b01);
        set_m(0, 0, 0, 0, 32'h0, 3'b000);
        tick(); #1;
        check("t4_gnt_t10", gnt, 0);
        check("t4_timeout_t10", timeout, 0);
        check("t4_m_err_t10", m_err, 0);
        tick();

        // Ack in the last watchdog cycle wins over the timeout.
        set_m(0, 1, 1, 0, 32'h600, 3'b000);
        tick();
        for (int c = 2; c <= 7; c++) begin
            tick();
        end
        #1;
        check("t5_timeout_u7", timeout, 0);
        tick();
        push(2'b01, 2'b00, 32'h0000CAFE, 2'b01, 1'b0);
        s_ack = 1'b1; s_dat_r = 32'h0000CAFE;
        #1;
        check("t5_s_cyc_u8", s_cyc, 1);
        tick();
        s_ack = 1'b0;
        #1;
        check("t5_timeout_u9", timeout, 0);
        check("t5_m_err_u9", m_err, 0);
        check("t5_s_cyc_u9", s_cyc, 1);
        check("t5_gnt_u9", gnt, 2'b01);
        set_m(0, 0, 0, 0, 32'h0, 3'b000);
        tick();
        tick();

        // Rotation: both masters re-request after every single-beat transfer.
        do_reset();
        set_m(0, 1, 1, 0, 32'h1000, 3'b000);
        set_m(1, 1, 1, 0, 32'h2000, 3'b000);
        g = 0;
        for (int k = 0; k < 20; k++) begin
            n = 0;
            while (gnt == 2'b00 && n < 10) begin
                tick(); #1;
                n++;
            end
            oh = (g == 0) ? 2'b01 : 2'b10;
            check("t6_rot_gnt", gnt, oh);
            push(oh, 2'b00, 32'(k), oh, 1'b0);
            s_ack = 1'b1; s_dat_r = 32'(k);
            m_cyc[g] = 1'b0;
            tick();
            s_ack = 1'b0;
            m_cyc = 2'b11;
            #1;
            g = 1 - g;
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();

        // Reset during a BUS stall owned by m1.
        set_m(1, 1, 1, 0, 32'h700, 3'b000);
        tick(); #1;
        check("t7_gnt_m1", gnt, 2'b10);
        tick();
        tick();
        rst = 1'b1;
        set_m(0, 1, 1, 0, 32'h710, 3'b000);
        tick(); #1;
        check("t7_rst_s_cyc", s_cyc, 0);
        check("t7_rst_gnt", gnt, 0);
        check("t7_rst_m_err", m_err, 0);
        check("t7_rst_timeout", timeout, 0);
        rst = 1'b0;
        tick(); #1;
        check("t7_after_rst_gnt", gnt, 2'b01);
        m_cyc = 2'b00; m_stb = 2'b00;
        tick();
        tick();
        tick();

        check("sb_empty", 64'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_wb_arbiter.md
# sdram_wb_arbiter

Round-robin Wishbone arbiter that lets several bus masters share the single Wishbone slave port of the SDRAM controller. The CPU instruction-fetch and data ports are the intended masters. Ownership is held for a whole CYC, including CTI bursts. A watchdog ends any transfer the slave never terminates by returning ERR to the owning master. The block sits between the masters and `sdram_ctrl`, in the Wishbone clock domain.

## Interface
**Parameters**
- `NM`, 2: number of masters, 2..4.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 1024: stalled STB cycles before forced termination, ≥2.

**Ports**
- `clk`  in  1  Wishbone clock.
- `rst`  in  1  synchronous, active-high reset.
- `m_cyc`, `m_stb`, `m_we`  in  NM each  per-master CYC/STB/WE; bit i belongs to master i.
- `m_adr`  in  NM*AW  per-master address; master i at [i*AW +: AW].
- `m_dat_w`  in  NM*DW  per-master write data.
- `m_cti`  in  NM*3  per-master cycle type.
- `m_ack`, `m_err`, `m_rty`  out  NM each  per-master termination.
- `m_dat_r`  out  DW  read data, broadcast to all masters.
- `s_cyc`, `s_stb`, `s_we`  out  1  to SDRAM controller.
- `s_adr`  out  AW; `s_dat_w`  out  DW; `s_cti`  out  3.
- `s_ack`, `s_err`, `s_rty`  in  1  from SDRAM controller.
- `s_dat_r`  in  DW  read data from SDRAM controller.
- `gnt`  out  NM  one-hot current owner; all zero when no master owns the bus.
- `timeout`  out  1  one-cycle pulse on watchdog termination.

## Operation
- States: IDLE, BUS, ERR_TERM, RELEASE.
- **IDLE**
  - All `s_*` control outputs are 0.
  - If any `m_cyc` is high, the winner is the first requester searching from index `last+1` upward, modulo NM.
  - The winner index is registered into `own` and the FSM moves to BUS.
- **BUS**
  - `s_cyc/s_stb/s_we/s_adr/s_dat_w/s_cti` are driven combinationally from master `own`.
  - `m_ack/m_err/m_rty[own]` follow `s_ack/s_err/s_rty` combinationally; these bits are 0 for every other master.
  - `m_dat_r` = `s_dat_r` at all times.
  - If `m_cyc[own]` is 0, go to RELEASE. In that cycle `s_cyc` is already 0 because it follows the master.
- **Watchdog**
  - Counter `wd` has width clog2(TIMEOUT+1).
  - Cleared outside BUS, when `s_stb` is 0, and on any of ack/err/rty. Otherwise it increments.
  - When `wd == TIMEOUT-1` and no termination arrives, go to ERR_TERM.
- **ERR_TERM** (exactly one cycle)
  - `s_cyc = s_stb = 0`.
  - `m_err[own] = 1` and `timeout = 1`.
  - Next state is RELEASE.
- **RELEASE** (exactly one cycle)
  - `s_cyc = 0`, `last <= own`, `gnt` = 0, next state IDLE.
  - This guarantees the SDRAM controller always sees CYC low for at least one cycle between owners.
- `gnt` = one-hot of `own` in BUS and ERR_TERM, 0 otherwise.
- Masters are never preempted. Fairness comes only from rotation at ownership boundaries.

## Timing
- **Reset**
  - state = IDLE, `own` = 0, `last` = NM-1 (so master 0 wins first), `wd` = 0.
  - All outputs are 0, including `gnt`, `timeout` and `s_cyc`, in the first cycle after the reset edge.
  - Reset asserted mid-BUS drops `s_cyc` immediately after the edge. No ack/err is produced for the aborted transfer.
- **Arbitration latency:** `m_cyc` rising at cycle t gives `s_cyc` high at t+1, assuming the FSM is in IDLE at t.
- **Handover:** owner drops `m_cyc` at t → RELEASE at t+1, IDLE at t+2 (arbitrates), next owner on `s_cyc` at t+3.
- **Ack while the owner drops CYC:** an `s_ack` in the same cycle that the owner drops `m_cyc` is still passed to that owner.
- **Termination vs watchdog:** termination arriving in the cycle `wd == TIMEOUT-1` wins. No ERR, `wd` clears.
- **Timeout timing:** with continuous stalled STB starting at cycle s, `m_err` and `timeout` pulse at s+TIMEOUT.
- **Burst beats:** each beat's ack passes through with zero added latency.
- **Unowned requests:** a master requesting while not the owner sees ack/err/rty = 0 for as long as it waits.

## Test plan
- **Single read:** NM=2. m0 read, adr 0x100 at t0; slave acks at t3 with 0xDEADBEEF → `s_cyc` high at t1, `gnt`=01, `m_ack[0]`=1 and `m_dat_r`=0xDEADBEEF at t3, `m_ack[1]`=0.
- **Simultaneous requests after reset:** both masters request at t0; m0 drops CYC at t5 → m0 owns from t1; RELEASE t6; IDLE t7; m1 on `s_cyc` at t8, `gnt`=10.
- **No preemption during a burst:** m1 runs a 4-beat CTI=010 burst (last beat CTI=111) while m0 requests mid-burst → all 4 acks go to m1, `m_ack[0]` stays 0, m0 is granted only after m1 drops CYC.
- **Watchdog:** TIMEOUT=8, slave never responds, STB high from t1 → `m_err[0]` and `timeout` pulse at t9, `s_cyc`=0 at t9, RELEASE at t10.
- **Rotation:** both masters re-request immediately after every single-beat transfer → grants alternate 0,1,0,1,… with no starvation over 20 transfers.
- **Reset mid-operation:** `rst` asserted during a BUS stall → next cycle state IDLE, `s_cyc`=0, `gnt`=0, no `m_err`; after release, m0 is granted first.
